pixel_scheduler: RTL and testbench
==================================

# pixel_scheduler

Frame-level controller that sits around one `iterator` instance: upstream it walks the screen in raster order and issues complex coordinates `c = c_r + j·c_i` to the iterator; downstream it accepts each escape count, maps it to an 8-bit colour, and writes that colour to the frame buffer. A single `start` pulse renders one full frame. All coordinates use signed 4.23 fixed point, 27 bits.

## Interface
Parameters:
- `H_RES`, 640: pixels per row.
- `V_RES`, 480: rows per frame.
- `ITER_MAX`, 1000: iteration cap; must match the iterator.
- `ADDR_W`, 19: frame-buffer address width; H_RES·V_RES ≤ 2^ADDR_W.

Ports (`ITER_W` = $clog2(ITER_MAX)+1):
- `clk`  in  1  single clock for the block.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin frame; sampled only in IDLE.
- `x_start`  in  27  signed 4.23 real part of pixel (0,0).
- `y_start`  in  27  signed 4.23 imaginary part of row 0 (top row).
- `dx`  in  27  signed 4.23 real step per column.
- `dy`  in  27  signed 4.23 imaginary decrement per row.
- `it_in_val`  out  1  coordinate valid to the iterator.
- `it_in_rdy`  in  1  iterator ready for a coordinate.
- `it_c_r`, `it_c_i`  out  27  coordinate to the iterator.
- `it_out_val`  in  1  iterator result valid.
- `it_iter_count`  in  ITER_W  iterator escape count.
- `it_out_rdy`  out  1  result accepted.
- `fb_we`  out  1  frame-buffer write strobe.
- `fb_addr`  out  ADDR_W  write address, y·H_RES + x.
- `fb_data`  out  8  colour.
- `busy`  out  1  high from the cycle after `start` is accepted until the final write completes.
- `done`  out  1  one-cycle pulse after the final write.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE: when `start`=1, latch `x_start`, `y_start`, `dx`, `dy`. Set x=0, y=0, `it_c_r`=x_start, `it_c_i`=y_start, `fb_addr`=0. Go to ISSUE.
- ISSUE: `it_in_val`=1 (decoded from state). When `it_in_val` and `it_in_rdy` are both high at a posedge, the transfer occurs and the FSM goes to WAIT. `it_c_r` and `it_c_i` are held stable while in ISSUE.
- WAIT: `it_out_rdy`=1 (decoded from state). When `it_out_val` is high at a posedge, register the colour into `fb_data` and go to WRITE.
- WRITE: `fb_we`=1 for exactly one cycle, with the current `fb_addr` and `fb_data`. At the edge leaving WRITE:
  - If this is the last pixel (x=H_RES-1, y=V_RES-1): go to IDLE and register `done`=1 for one cycle.
  - Else if x=H_RES-1: set x=0, y+=1, `it_c_r`=x_start, `it_c_i`-=dy.
  - Else: x+=1, `it_c_r`+=dx.
  - In the two non-final cases, `fb_addr`+=1 and go to ISSUE.
- Coordinates are produced by accumulation only, with no multiplier. Addition is 27-bit two's complement and wraps without saturation; keeping values in range is the caller's job.
- Colour map, from count n:
  - n ≥ ITER_MAX → 8'h00 (point in set).
  - 255 ≤ n < ITER_MAX → 8'h01.
  - Otherwise → 8'd255 − n[7:0].
- `start` is ignored outside IDLE. Frame parameters changing mid-frame have no effect.

## Timing
- Reset values: state IDLE, and all outputs 0 (`it_in_val`, `it_out_rdy`, `it_c_r`, `it_c_i`, `fb_we`, `fb_addr`, `fb_data`, `busy`, `done`). x and y counters are also 0.
- `start` high at edge k → ISSUE, `it_in_val`=1, and `busy`=1 from cycle k+1.
- Per-pixel cost is 3 cycles when the iterator accepts and answers immediately (ISSUE 1, WAIT ≥1, WRITE 1), plus iterator latency. Frame cost with a zero-latency iterator is 3·H_RES·V_RES cycles.
- `done` is high in the cycle after the final WRITE. `busy` is low in that same cycle, and a new `start` may be accepted in that cycle.
- `it_in_val` never drops without a completed transfer. `it_out_rdy` stays high until a result arrives.
- Reset mid-frame: next cycle is IDLE with all outputs 0, and no partial write occurs. The system resets the iterator with the same `reset`.

## Test plan
Benches use a behavioural iterator stub with programmable counts and latency unless stated, and H_RES=4, V_RES=3.
- Reset: assert `reset` 3 cycles → every output 0, `busy`=0, FSM accepts `start` next cycle.
- Full frame: x_start=−2.0, dx=0.5, y_start=1.0, dy=1.0; stub accepts and answers with 0 latency → 12 writes, `fb_addr` 0..11 in order, each ISSUE presents the correct c (pixel (2,1) = −1.0+0.0i), `done` pulses once at cycle 36 after `start`.
- Backpressure: stub holds `it_in_rdy` low 5 cycles, then `it_out_val` delayed 7 cycles → `it_in_val` high and `it_c_r`/`it_c_i` stable throughout, exactly one write per pixel.
- Colour boundaries: counts 1, 254, 255, 999, 1000 → `fb_data` 0xFE, 0x01, 0x01, 0x01, 0x00.
- Control: `start` pulsed mid-frame → ignored, frame unchanged. Reset at pixel 5 → no further `fb_we`. A new `start` renders a full frame from addr 0.
- Integration with the real iterator, single pixel (H_RES=V_RES=1), x_start=y_start=0 → `fb_data`=0x00, `done` pulses.

Source files
------------

// File: rtl/pixel_scheduler.sv
// Raster-order frame walker around one iterator: issues c per pixel, maps escape count to colour, writes the frame buffer.
// Latency: 3 cycles per pixel plus iterator latency; stalls in ISSUE/WAIT under iterator backpressure, nothing dropped.
module pixel_scheduler #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ITER_MAX = 1000,
  parameter int ADDR_W   = 19,
  localparam int ITER_W  = $clog2(ITER_MAX) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [26:0]  x_start,
  input  logic signed [26:0]  y_start,
  input  logic signed [26:0]  dx,
  input  logic signed [26:0]  dy,
  output logic                it_in_val,
  input  logic                it_in_rdy,
  output logic signed [26:0]  it_c_r,
  output logic signed [26:0]  it_c_i,
  input  logic                it_out_val,
  input  logic [ITER_W-1:0]   it_iter_count,
  output logic                it_out_rdy,
  output logic                fb_we,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [7:0]          fb_data,
  output logic                busy,
  output logic                done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic signed [26:0] xs_q, xs_d;
  logic signed [26:0] dx_q, dx_d;
  logic signed [26:0] dy_q, dy_d;
  logic signed [26:0] c_r_q, c_r_d;
  logic signed [26:0] c_i_q, c_i_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               done_q, done_d;
  logic               x_end, last_pix;

  function automatic logic [7:0] colour(input logic [ITER_W-1:0] n);
    if (n >= ITER_W'(ITER_MAX))
      colour = 8'h00;
    else if (n >= ITER_W'(255))
      colour = 8'h01;
    else
      colour = 8'hFF - n[7:0];
  endfunction

  assign x_end    = (x_q == X_LAST);
  assign last_pix = x_end && (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_ISSUE;
      S_ISSUE: if (it_in_rdy)  state_d = S_WAIT;
      S_WAIT:  if (it_out_val) state_d = S_WRITE;
      S_WRITE: state_d = last_pix ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    it_in_val  = (state_q == S_ISSUE);
    it_out_rdy = (state_q == S_WAIT);
    fb_we      = (state_q == S_WRITE);
    busy       = (state_q != S_IDLE);
  end

  // Coordinates advance by accumulation only; wrap is left to the caller.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xs_d   = xs_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    c_r_d  = c_r_q;
    c_i_d  = c_i_q;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          xs_d   = x_start;
          dx_d   = dx;
          dy_d   = dy;
          x_d    = '0;
          y_d    = '0;
          c_r_d  = x_start;
          c_i_d  = y_start;
          addr_d = '0;
        end
      end
      S_WAIT: begin
        if (it_out_val) data_d = colour(it_iter_count);
      end
      S_WRITE: begin
        if (last_pix) begin
          done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_end) begin
            x_d   = '0;
            y_d   = y_q + YW'(1);
            c_r_d = xs_q;
            c_i_d = c_i_q - dy_q;
          end else begin
            x_d   = x_q + XW'(1);
            c_r_d = c_r_q + dx_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      xs_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      c_r_q  <= '0;
      c_i_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xs_q   <= xs_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      c_r_q  <= c_r_d;
      c_i_q  <= c_i_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign it_c_r  = c_r_q;
  assign it_c_i  = c_i_q;
  assign fb_addr = addr_q;
  assign fb_data = data_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x3 frame with a programmable iterator stub.
module tb_pixel_scheduler;

  localparam int NPIX = 12;

  logic        clk;
  logic        reset, start;
  logic [26:0] x_start, y_start, dx, dy;
  logic        it_in_val, it_in_rdy, it_out_val, it_out_rdy;
  logic [26:0] it_c_r, it_c_i;
  logic [10:0] it_iter_count;
  logic        fb_we, busy, done;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;

  pixel_scheduler #(.H_RES(4), .V_RES(3), .ITER_MAX(1000), .ADDR_W(19)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_start(x_start), .y_start(y_start), .dx(dx), .dy(dy),
    .it_in_val(it_in_val), .it_in_rdy(it_in_rdy),
    .it_c_r(it_c_r), .it_c_i(it_c_i),
    .it_out_val(it_out_val), .it_iter_count(it_iter_count), .it_out_rdy(it_out_rdy),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub / monitor state
  logic [10:0] counts [NPIX];
  logic [7:0]  colours[NPIX];
  logic [26:0] m_xs, m_ys, m_dx, m_dy;
  int  cyc = 0;
  int  rdy_delay = 0, out_delay = 0, rcnt = 0, lat = 0;
  int  idx = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, stray = 0;
  bit  pending = 0, accept_now = 0, no_we = 0, pix_chk = 0;

  function automatic logic [26:0] exp_cr(input int p);
    exp_cr = m_xs + 27'(p % 4) * m_dx;
  endfunction

  function automatic logic [26:0] exp_ci(input int p);
    exp_ci = m_ys - 27'(p / 4) * m_dy;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Iterator stub plus write/done monitor, evaluated on the falling edge.
  initial begin
    it_in_rdy = 1'b0;
    it_out_val = 1'b0;
    it_iter_count = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 0; accept_now = 0; rcnt = 0; lat = 0;
        it_in_rdy = 1'b0; it_out_val = 1'b0;
      end else begin
        if (fb_we) begin
          if (no_we) stray++;
          else begin
            if (wr_cnt < NPIX) begin
              check("wr_addr", 64'(fb_addr), 64'(wr_cnt));
              check("wr_data", 64'(fb_data), 64'(colours[wr_cnt]));
            end
            wr_cnt++;
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("busy_at_done", 64'(busy), 64'd0);
        end
        if (accept_now) begin
          pending = 1; lat = 0; accept_now = 0;
        end
        it_in_rdy = 1'b0;
        it_out_val = 1'b0;
        if (!pending && (it_in_val || rcnt != 0)) begin
          if (rcnt != 0) check("inval_hold", 64'(it_in_val), 64'd1);
          if (idx < NPIX) begin
            check("c_r", 64'(it_c_r), 64'(exp_cr(idx)));
            check("c_i", 64'(it_c_i), 64'(exp_ci(idx)));
            if (pix_chk && idx == 6) begin
              check("pix21_r", 64'(it_c_r), 64'h7800000);
              check("pix21_i", 64'(it_c_i), 64'h0);
            end
          end
          if (rcnt >= rdy_delay) begin
            it_in_rdy = 1'b1; accept_now = 1; rcnt = 0;
          end else rcnt++;
        end
        if (pending) begin
          if (lat != 0) check("outrdy_hold", 64'(it_out_rdy), 64'd1);
          if (lat >= out_delay) begin
            it_out_val = 1'b1;
            it_iter_count = counts[idx % NPIX];
            pending = 0;
            idx++;
          end else lat++;
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_inval"}, 64'(it_in_val), 64'd0);
    check({tag, "_outrdy"}, 64'(it_out_rdy), 64'd0);
    check({tag, "_cr"}, 64'(it_c_r), 64'd0);
    check({tag, "_ci"}, 64'(it_c_i), 64'd0);
    check({tag, "_we"}, 64'(fb_we), 64'd0);
    check({tag, "_addr"}, 64'(fb_addr), 64'd0);
    check({tag, "_data"}, 64'(fb_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic begin_frame(input int rd, input int od, output int s_cyc);
    rdy_delay = rd; out_delay = od;
    idx = 0; wr_cnt = 0; done_cnt = 0; rcnt = 0;
    m_xs = x_start; m_ys = y_start; m_dx = dx; m_dy = dy;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    s_cyc = cyc;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("inval_after_start", 64'(it_in_val), 64'd1);
  endtask

  task automatic run_frame(input int rd, input int od, input bit poke, input bit chk_lat);
    int s_cyc;
    begin_frame(rd, od, s_cyc);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(negedge clk);
      if (poke && i == 20) begin
        start = 1'b1; x_start = 27'h1234567; dx = 27'h0000123; dy = 27'h7654321;
      end
      if (poke && i == 21) start = 1'b0;
    end
    if (done_cnt == 0) check("frame_timeout", 64'd0, 64'd1);
    repeat (8) @(negedge clk);
    check("frame_writes", 64'(wr_cnt), 64'd12);
    check("frame_done_cnt", 64'(done_cnt), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    if (chk_lat) check("done_latency", 64'(done_cyc - s_cyc), 64'd36);
    x_start = m_xs; dx = m_dx; dy = m_dy;
  endtask

  initial begin
    int s_cyc;
    reset = 1'b1; start = 1'b0;
    x_start = 27'h7000000;   // -2.0
    y_start = 27'h0800000;   //  1.0
    dx      = 27'h0400000;   //  0.5
    dy      = 27'h0800000;   //  1.0
    counts  = '{11'd0, 11'd1, 11'd254, 11'd255, 11'd999, 11'd1000,
                11'd17, 11'd128, 11'd1500, 11'd200, 11'd50, 11'd3};
    colours = '{8'hFF, 8'hFE, 8'h01, 8'h01, 8'h01, 8'h00,
                8'hEE, 8'h7F, 8'h00, 8'h37, 8'hCD, 8'hFC};

    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // Zero-latency frame, start taken on the first cycle after reset.
    pix_chk = 1;
    run_frame(0, 0, 1'b0, 1'b1);
    pix_chk = 0;

    // Backpressure with a mid-frame start pulse and parameter change.
    run_frame(5, 7, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("no_restart_busy", 64'(busy), 64'd0);

    // Reset after five pixels have been written.
    begin_frame(0, 0, s_cyc);
    for (int i = 0; i < 200 && wr_cnt < 5; i++) @(negedge clk);
    check("reached_pix5", 64'(wr_cnt >= 5), 64'd1);
    no_we = 1;
    reset = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("midreset_stray_we", 64'(stray), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    no_we = 0;

    // Fresh frame after the abort starts again from address 0.
    run_frame(0, 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
